// File: rtl/i2c_regbank.sv
// i2c_regbank: application register bank behind the I2C slave bus.
// Provides an ID register, CTRL/STATUS/LEVEL, an RX FIFO drained by I2C
// reads at 0x04, a write mailbox at 0x04 and eight scratch registers.
// The 0x08 scratch register drives gpio_out.
// Optional feature macro: I2C_REGBANK_IRQ_EN (THRESH register at 0x05 and irq).
module i2c_regbank #(
    parameter logic [7:0] CHIP_ID    = 8'hA5,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic       wen,
    input  logic [7:0] wdata,
    input  logic       rdata_used,
    output logic [7:0] rdata,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic [7:0] mbox_data,
    output logic       mbox_valid,
    output logic [7:0] gpio_out,
    output logic       irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             irq_ena;
    logic [7:0]       scratch [8];
    logic [7:0]       thresh;
    logic [7:0]       level;
    logic [7:0]       rd_mux;

    logic is_empty, is_full, flush, pop, push_ok, ovf_set, ovf_clr;

    // rw carries no decode information; it is kept on the port list only.
    logic unused_rw;
    assign unused_rw = rw;

    assign level    = 8'(count);
    assign is_empty = (count == '0);
    assign is_full  = (count == CNT_W'(FIFO_DEPTH));
    // Flush beats a simultaneous push; a full FIFO drops the push even if a pop happens.
    assign flush    = wen && (addr == 8'h01) && wdata[0];
    assign pop      = rdata_used && (addr == 8'h04) && !is_empty && !flush;
    assign push_ok  = in_valid && !is_full && !flush;
    assign ovf_set  = in_valid && is_full && !flush;
    assign ovf_clr  = rdata_used && (addr == 8'h02);

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
        if (rst)          ovf <= 1'b0;
        else if (ovf_set) ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end

    // FIFO storage; contents are discarded logically by resetting the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= in_data;
    end

    // Software-writable registers, mailbox and its one-cycle valid strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_ena    <= 1'b0;
            mbox_data  <= 8'h00;
            mbox_valid <= 1'b0;
            for (int i = 0; i < 8; i++) scratch[i] <= 8'h00;
        end else begin
            mbox_valid <= wen && (addr == 8'h04);
            if (wen && addr == 8'h01) irq_ena <= wdata[1];
            if (wen && addr == 8'h04) mbox_data <= wdata;
            if (wen && addr[7:3] == 5'b00001) scratch[addr[2:0]] <= wdata;
        end
    end

    assign gpio_out = scratch[0];

`ifdef I2C_REGBANK_IRQ_EN
    // Interrupt threshold register.
    always_ff @(posedge clk) begin
        if (rst)                       thresh <= 8'h01;
        else if (wen && addr == 8'h05) thresh <= wdata;
    end

    // Registered level interrupt: FIFO reached threshold or overflow seen.
    always_ff @(posedge clk) begin
        if (rst) irq <= 1'b0;
        else     irq <= irq_ena && ((level >= thresh) || ovf);
    end
`else
    assign thresh = 8'h00;
    assign irq    = 1'b0;
`endif

    // Read decode of the current address against the current state.
    always_comb begin
        rd_mux = 8'h00;
        if (addr[7:4] == 4'h0) begin
            case (addr[3:0])
                4'h0:    rd_mux = CHIP_ID;
                4'h1:    rd_mux = {6'b0, irq_ena, 1'b0};
                4'h2:    rd_mux = {5'b0, ovf, is_full, is_empty};
                4'h3:    rd_mux = level;
                4'h4:    rd_mux = is_empty ? 8'h00 : mem[rd_ptr];
                4'h5:    rd_mux = thresh;
                4'h6,
                4'h7:    rd_mux = 8'h00;
                default: rd_mux = scratch[addr[2:0]];
            endcase
        end
    end

    // Registered read data presented to the slave.
    always_ff @(posedge clk) begin
        if (rst) rdata <= 8'h00;
        else     rdata <= rd_mux;
    end
endmodule

// File: tb/tb_i2c_regbank.sv
// tb_i2c_regbank: scoreboard bench for i2c_regbank with a queue-based
// reference model, directed scenarios followed by randomized traffic.
module tb_i2c_regbank;
    localparam int DEPTH = 8;
`ifdef I2C_REGBANK_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rw = 1'b0;
    logic [7:0] addr = 8'h00;
    logic       wen = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       rdata_used = 1'b0;
    logic [7:0] rdata;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic [7:0] mbox_data;
    logic       mbox_valid;
    logic [7:0] gpio_out;
    logic       irq;

    i2c_regbank #(.CHIP_ID(8'hA5), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rw(rw), .addr(addr), .wen(wen), .wdata(wdata),
        .rdata_used(rdata_used), .rdata(rdata), .in_data(in_data),
        .in_valid(in_valid), .mbox_data(mbox_data), .mbox_valid(mbox_valid),
        .gpio_out(gpio_out), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rdata;
        logic [7:0] gpio;
        logic [7:0] mbox_data;
        logic       mbox_valid;
        logic       irq;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic       m_ena;
    logic       m_ovf;
    logic [7:0] m_thresh;
    logic [7:0] m_scr[8];
    logic [7:0] m_mbox;

    function automatic logic [7:0] mread(input logic [7:0] a);
        if (a >= 8'h10) return 8'h00;
        if (a == 8'h00) return 8'hA5;
        if (a == 8'h01) return {6'b0, m_ena, 1'b0};
        if (a == 8'h02) return {5'b0, m_ovf, m_q.size() == DEPTH, m_q.size() == 0};
        if (a == 8'h03) return 8'(m_q.size());
        if (a == 8'h04) return (m_q.size() > 0) ? m_q[0] : 8'h00;
        if (a == 8'h05) return IRQ_EN ? m_thresh : 8'h00;
        if (a >= 8'h08) return m_scr[a - 8'h08];
        return 8'h00;
    endfunction

    task automatic cyc(input bit r, input logic [7:0] a, input bit w, input logic [7:0] wd,
                       input bit ru, input bit iv, input logic [7:0] id);
        exp_t e;
        bit   was_full;
        @(negedge clk);
        rst = r; addr = a; wen = w; wdata = wd; rdata_used = ru; in_valid = iv; in_data = id;
        rw = ru;
        if (r) begin
            m_q.delete();
            m_ena = 0; m_ovf = 0; m_thresh = 8'h01; m_mbox = 8'h00;
            for (int i = 0; i < 8; i++) m_scr[i] = 8'h00;
            e.rdata = 8'h00; e.mbox_valid = 0; e.irq = 0;
        end else begin
            e.rdata = mread(a);
            e.irq = IRQ_EN && m_ena && ((m_q.size() >= int'(m_thresh)) || m_ovf);
            e.mbox_valid = w && (a == 8'h04);
            was_full = (m_q.size() == DEPTH);
            if (w && a == 8'h01 && wd[0]) begin
                m_q.delete();
            end else begin
                if (ru && a == 8'h04 && m_q.size() > 0) void'(m_q.pop_front());
                if (iv && !was_full) m_q.push_back(id);
                if (iv && was_full) m_ovf = 1;
                else if (ru && a == 8'h02) m_ovf = 0;
            end
            if (w) begin
                if (a == 8'h01) m_ena = wd[1];
                if (a == 8'h04) m_mbox = wd;
                if (a == 8'h05) m_thresh = wd;
                if (a >= 8'h08 && a <= 8'h0F) m_scr[a - 8'h08] = wd;
            end
        end
        e.gpio = m_scr[0];
        e.mbox_data = m_mbox;
        sbq.push_back(e);
    endtask

    task automatic idle(input logic [7:0] a);
        cyc(0, a, 0, 8'h00, 0, 0, 8'h00);
    endtask
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        cyc(0, a, 1, d, 0, 0, 8'h00);
    endtask
    task automatic push(input logic [7:0] a, input logic [7:0] d);
        cyc(0, a, 0, 8'h00, 0, 1, d);
    endtask
    task automatic used(input logic [7:0] a);
        cyc(0, a, 0, 8'h00, 1, 0, 8'h00);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per clock and compares all outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("rdata", rdata, e.rdata);
                chk("gpio_out", gpio_out, e.gpio);
                chk("mbox_valid", {7'b0, mbox_valid}, {7'b0, e.mbox_valid});
                chk("mbox_data", mbox_data, e.mbox_data);
                chk("irq", {7'b0, irq}, {7'b0, e.irq});
            end
        end
    end

    initial begin
        int iv_pct;
        logic [7:0] a;
        cyc(1, 8'h00, 0, 8'h00, 0, 0, 8'h00);
        cyc(1, 8'h00, 0, 8'h00, 0, 0, 8'h00);
        idle(8'h00); idle(8'h00); idle(8'h02); idle(8'h02);
        // Scratch / gpio and out-of-range write
        wr(8'h08, 8'h3C); idle(8'h08); idle(8'h08);
        wr(8'h20, 8'hFF); idle(8'h20); idle(8'h08); idle(8'h08);
        // FIFO fill and drain, including a pop on empty
        push(8'h04, 8'h11); push(8'h04, 8'h22); push(8'h04, 8'h33); idle(8'h04); idle(8'h03);
        for (int i = 0; i < 4; i++) begin
            used(8'h04); idle(8'h04); idle(8'h03); idle(8'h03);
        end
        // Overflow, sticky clear, flush
        for (int i = 0; i < 9; i++) push(8'h02, 8'(8'h40 + i));
        idle(8'h02); idle(8'h02); used(8'h02); idle(8'h02); idle(8'h02);
        wr(8'h01, 8'h01); idle(8'h03); idle(8'h03); idle(8'h02); idle(8'h01); idle(8'h01);
        // Mailbox, then simultaneous push and pop at level 2
        wr(8'h04, 8'h5A); idle(8'h03); idle(8'h03); idle(8'h03);
        push(8'h03, 8'hA1); push(8'h03, 8'hA2); idle(8'h03);
        cyc(0, 8'h04, 0, 8'h00, 1, 1, 8'hA3); idle(8'h03); idle(8'h03); idle(8'h04);
        // Flush beats push; overflow stays clear
        cyc(0, 8'h01, 1, 8'h01, 0, 1, 8'h77); idle(8'h03); idle(8'h02); idle(8'h02);
        // Interrupt threshold
        wr(8'h01, 8'h02); wr(8'h05, 8'h03); idle(8'h05);
        push(8'h05, 8'h01); push(8'h05, 8'h02); push(8'h05, 8'h03); idle(8'h04); idle(8'h04);
        used(8'h04); idle(8'h04); idle(8'h04); idle(8'h04);
        wr(8'h05, 8'h00); idle(8'h05); idle(8'h05); idle(8'h05);
        wr(8'h01, 8'h00); idle(8'h00); idle(8'h00);
        // Randomized traffic
        iv_pct = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) iv_pct = (n / 150 % 3 == 0) ? 20 : ((n / 150 % 3 == 1) ? 90 : 50);
            a = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
            cyc($urandom_range(0, 299) == 0, a,
                $urandom_range(0, 3) == 0, 8'($urandom),
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 99) < iv_pct, 8'($urandom));
        end
        idle(8'h00);
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
